// File: rtl/jk_moore_pkg.sv
// Shared types and default widths for the jk_moore_array channel bank.
// The optional transition counters are enabled with the JKM_TCNT_EN macro.
package jk_moore_pkg;

    typedef enum logic {
        S_OFF = 1'b0,
        S_ON  = 1'b1
    } jkm_state_e;

    localparam int JKM_CH_DEF     = 4;
    localparam int JKM_HOLD_W_DEF = 4;
    localparam int JKM_CNT_W_DEF  = 8;

    // OFF listens only to j and ON listens only to k, so j&k acts as a toggle.
    function automatic logic jkm_request(input jkm_state_e s, input logic j, input logic k);
        return (s == S_OFF) ? j : k;
    endfunction

endpackage

// File: rtl/jk_moore_cell.sv
// One JK-style Moore channel: ON/OFF state, dwell lockout counter, and a
// saturating transition counter that exists only when JKM_TCNT_EN is defined.
module jk_moore_cell
    import jk_moore_pkg::*;
#(
    parameter int HOLD_W = JKM_HOLD_W_DEF,
    parameter int CNT_W  = JKM_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              j,
    input  logic              k,
    input  logic [HOLD_W-1:0] dwell,
    input  logic              cnt_clr,
    output logic              out,
    output logic              busy,
    output logic [CNT_W-1:0]  tcnt
);

    jkm_state_e        state_p0;
    logic [HOLD_W-1:0] hold_p0;
    logic              idle;
    logic              take;

    assign idle = (hold_p0 == '0);
    assign take = idle && jkm_request(state_p0, j, k);

    // p0: state and dwell counter; requests arriving mid-dwell are dropped, not queued
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0 <= S_OFF;
            hold_p0  <= '0;
        end else if (!idle) begin
            hold_p0 <= hold_p0 - HOLD_W'(1);
        end else if (take) begin
            state_p0 <= (state_p0 == S_ON) ? S_OFF : S_ON;
            hold_p0  <= dwell;
        end
    end

    assign out  = (state_p0 == S_ON);
    assign busy = !idle;

`ifdef JKM_TCNT_EN
    logic [CNT_W-1:0] tcnt_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // p0: transition count; a clear on the same edge as a transition wins
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            tcnt_p0 <= '0;
        end else if (take) begin
            tcnt_p0 <= sat_inc(tcnt_p0);
        end
    end

    assign tcnt = tcnt_p0;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign tcnt           = '0;
`endif

endmodule

// File: rtl/jk_moore_array.sv
// Bank of CH independent rate-limited JK Moore channels; this level only
// slices and packs per-channel buses. Optional counters: JKM_TCNT_EN.
module jk_moore_array
    import jk_moore_pkg::*;
#(
    parameter int CH     = JKM_CH_DEF,
    parameter int HOLD_W = JKM_HOLD_W_DEF,
    parameter int CNT_W  = JKM_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH-1:0]       j,
    input  logic [CH-1:0]       k,
    input  logic [HOLD_W-1:0]   dwell,
    output logic [CH-1:0]       out,
    output logic [CH-1:0]       busy,
    input  logic                cnt_clr,
    output logic [CH*CNT_W-1:0] tcnt
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        jk_moore_cell #(
            .HOLD_W (HOLD_W),
            .CNT_W  (CNT_W)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .j       (j[g]),
            .k       (k[g]),
            .dwell   (dwell),
            .cnt_clr (cnt_clr),
            .out     (out[g]),
            .busy    (busy[g]),
            .tcnt    (tcnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_jk_moore_array.sv
// Self-checking bench for jk_moore_array: directed scenarios plus random traffic
// compared against an integer-level channel model.
module tb_jk_moore_array;

    localparam int CH     = 4;
    localparam int HOLD_W = 4;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cnt_clr = 1'b0;
    logic [CH-1:0]       j = '0;
    logic [CH-1:0]       k = '0;
    logic [HOLD_W-1:0]   dwell = '0;
    logic [CH-1:0]       out;
    logic [CH-1:0]       busy;
    logic [CH*CNT_W-1:0] tcnt;

    int total = 0;
    int bad   = 0;

    // Reference: level (0/1), remaining lockout cycles, transitions taken
    int m_lvl  [CH];
    int m_hold [CH];
    int m_tc   [CH];

    jk_moore_array #(.CH(CH), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .j       (j),
        .k       (k),
        .dwell   (dwell),
        .out     (out),
        .busy    (busy),
        .cnt_clr (cnt_clr),
        .tcnt    (tcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < CH; i++) begin
            if (reset) begin
                m_lvl[i] = 0; m_hold[i] = 0; m_tc[i] = 0;
            end else begin
                bit fire;
                fire = 0;
                if (m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
                else if ((m_lvl[i] == 0 && j[i]) || (m_lvl[i] == 1 && k[i])) begin
                    fire = 1;
                    m_lvl[i]  = 1 - m_lvl[i];
                    m_hold[i] = int'(dwell);
                end
`ifdef JKM_TCNT_EN
                if (cnt_clr) m_tc[i] = 0;
                else if (fire && m_tc[i] < CMAX) m_tc[i] = m_tc[i] + 1;
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [CH-1:0]       eo, eb;
        logic [CH*CNT_W-1:0] et;
        for (int i = 0; i < CH; i++) begin
            eo[i] = (m_lvl[i] != 0);
            eb[i] = (m_hold[i] != 0);
            et[i*CNT_W +: CNT_W] = m_tc[i][CNT_W-1:0];
        end
        chk({tag, ".out"}, 64'(out), 64'(eo));
        chk({tag, ".busy"}, 64'(busy), 64'(eb));
        chk({tag, ".tcnt"}, 64'(tcnt), 64'(et));
    endtask

    task automatic step(input string tag, input logic [CH-1:0] jj, input logic [CH-1:0] kk,
                        input int dw, input logic rs, input logic cc);
        @(negedge clk);
        j = jj; k = kk; dwell = dw[HOLD_W-1:0]; reset = rs; cnt_clr = cc;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int changes;
        logic prev;
        for (int i = 0; i < CH; i++) begin m_lvl[i] = 0; m_hold[i] = 0; m_tc[i] = 0; end

        // 1: reset and idle hold
        step("rst", '0, '0, 0, 1'b1, 1'b0);
        step("rst", '0, '0, 0, 1'b1, 1'b0);
        chk("rst.out0", 64'(out), 64'h0);
        chk("rst.busy0", 64'(busy), 64'h0);
        chk("rst.tcnt0", 64'(tcnt), 64'h0);
        for (int n = 0; n < 10; n++) step("idle", '0, '0, 0, 1'b0, 1'b0);
        chk("idle.out", 64'(out), 64'h0);

        // 2: set then clear channel 0
        step("set0", 4'b0001, '0, 0, 1'b0, 1'b0);
        chk("set0.out", 64'(out), 64'h1);
        step("clr0", '0, 4'b0001, 0, 1'b0, 1'b0);
        chk("clr0.out", 64'(out), 64'h0);

        // 3: j=k=1 toggles every edge with dwell=0
        for (int n = 0; n < 6; n++) begin
            step("tog1", 4'b0010, 4'b0010, 0, 1'b0, 1'b0);
            chk("tog1.seq", 64'(out[1]), 64'((n % 2) == 0));
        end
        step("tog1_end", '0, '0, 0, 1'b0, 1'b0);

        // 4: dwell=3, held toggle on ch2 fires every 4th edge
        step("rst4", '0, '0, 0, 1'b1, 1'b0);
        changes = 0;
        prev = out[2];
        for (int n = 0; n < 12; n++) begin
            step("dw3", 4'b0100, 4'b0100, 3, 1'b0, 1'b0);
            if (out[2] !== prev) changes++;
            prev = out[2];
        end
        chk("dw3.transitions", 64'(changes), 64'd3);
        step("dw3_on", 4'b0100, '0, 3, 1'b0, 1'b0);
        step("dw3_kdrop", '0, 4'b0100, 3, 1'b0, 1'b0);
        chk("dw3.kdrop_busy", 64'(busy[2]), 64'd1);

        // 5: reset mid-dwell
        step("rst5", '0, '0, 0, 1'b1, 1'b0);
        step("dw7_set", 4'b1000, '0, 7, 1'b0, 1'b0);
        step("dw7_wait", '0, '0, 7, 1'b0, 1'b0);
        step("dw7_rst", '0, '0, 7, 1'b1, 1'b0);
        chk("dw7.out3", 64'(out[3]), 64'd0);
        chk("dw7.busy3", 64'(busy[3]), 64'd0);
        step("dw7_rst", '0, '0, 7, 1'b1, 1'b0);
        step("dw7_reset_on", 4'b1000, '0, 7, 1'b0, 1'b0);
        chk("dw7.reon", 64'(out[3]), 64'd1);

        // 6: counter saturation and clear
        step("rst6", '0, '0, 0, 1'b1, 1'b0);
        for (int n = 0; n < 300; n++) step("sat", 4'b0001, 4'b0001, 0, 1'b0, 1'b0);
`ifdef JKM_TCNT_EN
        chk("sat.tcnt0", 64'(tcnt[CNT_W-1:0]), 64'(CMAX));
`else
        chk("sat.tcnt0", 64'(tcnt[CNT_W-1:0]), 64'd0);
`endif
        step("cclr", 4'b0001, 4'b0001, 0, 1'b0, 1'b1);
        chk("cclr.tcnt", 64'(tcnt), 64'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step("rnd", CH'($urandom), CH'($urandom), int'($urandom_range(0, 5)),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
